bit_serial_subtractor: RTL
==========================

# bit_serial_subtractor

Bit-serial N-bit subtractor that computes `d = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the team's 1-bit full-adder cells, trading area for latency. It sits behind a start/busy/done handshake so that a controller or testbench can issue one operation at a time.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 1.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted `start` edge.
- `bin`  in  1  borrow-in; captured on the accepted `start` edge.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse marking that `d`, `bout` and `zero` have just updated.
- `d`  out  WIDTH  difference, `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  final borrow; 1 when `a < b + bin` (unsigned).
- `zero`  out  1  high when `d == 0`.

## Operation
- States:
  - IDLE: `busy` = 0.
  - SHIFT: `busy` = 1.
- IDLE → SHIFT when `start` = 1 at a rising edge. On that edge:
  - `a` and `b` load into the shift registers `sa` and `sb`.
  - The borrow flip-flop `br` loads `bin`.
  - The bit counter clears to 0.
- Each SHIFT edge:
  - `dbit = sa[0] ^ sb[0] ^ br`.
  - `br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`.
  - `sa` and `sb` shift right by one.
  - The internal result register `sr` shifts right with `dbit` entering at MSB.
  - The counter increments.
- On the SHIFT edge that processes bit WIDTH-1 (counter = WIDTH-1):
  - `d ← {dbit, sr[WIDTH-1:1]}`.
  - `bout ← new br`.
  - `zero ← (that value == 0)`.
  - `done ← 1`.
  - State → IDLE.
- `done` clears on the next edge.
- `d`, `bout` and `zero` hold their values until the next completion. They never show partial results.
- `start` is ignored while in SHIFT, and changes on `a`, `b` or `bin` during SHIFT have no effect.
- `start` is accepted in IDLE even in the cycle where `done` = 1.
- WIDTH = 1: SHIFT lasts exactly one edge.

## Timing
- Reset, asynchronous on `rst` = 1: state = IDLE, `busy` = 0, `done` = 0, `d` = 0, `bout` = 0, `zero` = 1. The internal registers `sa`, `sb`, `sr`, `br` and the counter all clear to 0.
- Reset mid-operation aborts: no `done` is produced and the outputs return to their reset values.
- Start sampled at edge T0:
  - `busy` = 1 from T0 until edge T0+WIDTH.
  - At T0+WIDTH: `busy` → 0, `done` → 1, and the results are valid.
  - `done` → 0 at T0+WIDTH+1.
- Latency: WIDTH cycles from accepted start to `done`.
- Throughput: if `start` is held high, the next operation is accepted at T0+WIDTH+1. That gives one op per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, reset then release, idle:
  - outputs are `d` = 0x00, `bout` = 0, `zero` = 1, `busy` = 0, `done` = 0.
  - `start` pulse with `a` = 0x5A, `b` = 0x23, `bin` = 0 → `done` exactly 8 cycles later, `d` = 0x37, `bout` = 0, `zero` = 0.
- `a` = 0x23, `b` = 0x5A, `bin` = 0 → `d` = 0xC9, `bout` = 1, `zero` = 0. Then `a` = 0x00, `b` = 0x00, `bin` = 1 → `d` = 0xFF, `bout` = 1.
- `a` = 0x40, `b` = 0x3F, `bin` = 1 → `d` = 0x00, `bout` = 0, `zero` = 1.
- Start an op with `a` = 0x5A, `b` = 0x23. Then, 3 cycles in, pulse `start` with `a` = 0xFF, `b` = 0x01 and change `a`/`b` → the second start is ignored, the result is 0x37, and there is exactly one `done`.
- Assert `rst` asynchronously (mid-cycle) 4 cycles into an op → `busy` = 0, `d` = 0x00, `zero` = 1 immediately. No `done` follows, and a fresh start afterwards completes correctly.
- Hold `start` = 1 with operand pairs changed after each `done`:
  - `done` pulses every 9 cycles and each result matches its pair.
  - Randomised 1000-op run checks `{bout, d}` == `a - b - bin` in 9-bit two's complement.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: d = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  // A 1-bit counter still works for WIDTH = 1: LAST is 0, so SHIFT lasts one edge.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_zero;

  logic             w_dbit;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_next;

  // Full-subtractor cell.
  assign w_dbit    = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_sr_next = (r_sr >> 1) | (WIDTH'(w_dbit) << (WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SHIFT;
      SHIFT:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_next;
          r_br  <= w_br_next;
          r_cnt <= r_cnt + 1'b1;
          // Visible outputs only change here, so partial results never leak.
          if (w_last) begin
            r_d    <= w_sr_next;
            r_bout <= w_br_next;
            r_zero <= (w_sr_next == '0);
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;
  assign zero = r_zero;

endmodule
